// File: rtl/video_pkg.sv
// video_pkg: shared video-path capture states, constants and vsync normalisation
package video_pkg;
  typedef enum logic [1:0] {WAIT_SYNC, SYNC, ACTIVE, DROP} cap_state_t;
  localparam logic [7:0] pad_byte = 8'h00;
  localparam int cnt_w_default = 14;
  function automatic logic vsync_norm(input logic vsync, input logic pol);
    return pol ? vsync : ~vsync;
  endfunction
endpackage

// File: rtl/video_pos_counter.sv
// video_pos_counter: den edge detection with saturating x/y position counters and sync clear
module video_pos_counter
  import video_pkg::*;
#(
  parameter int cnt_w = cnt_w_default
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             den,
  output logic [cnt_w-1:0] pixel_x,
  output logic [cnt_w-1:0] pixel_y
);
  localparam logic [cnt_w-1:0] cnt_max = '1;
  logic den_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      den_d   <= 1'b0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else begin
      den_d <= den;
      if (clr) begin
        pixel_x <= '0;
        pixel_y <= '0;
      end else if (en && den) begin
        pixel_x <= pixel_x == cnt_max ? pixel_x : pixel_x + 1'b1;
      end else if (en && den_d) begin
        pixel_x <= '0;
        pixel_y <= pixel_y == cnt_max ? pixel_y : pixel_y + 1'b1;
      end
    end
  end
endmodule

// File: rtl/video_capture_writer.sv
// video_capture_writer: crops a raster video stream into the frame-buffer write FIFO with overflow drop
module video_capture_writer
  import video_pkg::*;
#(
  parameter int source_h        = 800,
  parameter int source_v        = 480,
  parameter bit video_vsync_pol = 1'b1,
  parameter int cnt_w           = cnt_w_default
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        video_vsync,
  input  logic        video_hsync,
  input  logic        video_den,
  input  logic [23:0] video_pixel,
  output logic        wr_load,
  output logic        wr_clk,
  output logic        wrfifo_wren,
  output logic [31:0] wrfifo_din,
  input  logic        wrfifo_full,
  output logic        frame_done,
  output logic        frame_overflow,
  output logic        overflow_sticky
);
  cap_state_t state, state_n;
  logic vs_act, vs_rise, active, want, wr, ovf, last;
  logic [cnt_w-1:0] pixel_x, pixel_y;
  logic unused_hsync;
  assign unused_hsync = video_hsync;
  assign wr_clk = pixel_clock;
  video_pos_counter #(.cnt_w(cnt_w)) u_pos (
    .clk    (pixel_clock),
    .rst    (!reset),
    .clr    (vs_rise || !active),
    .en     (active),
    .den    (video_den),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y)
  );
  always_comb begin
    vs_act  = vsync_norm(video_vsync, video_vsync_pol);
    vs_rise = vs_act && !wr_load;
    active  = state == ACTIVE;
    want    = active && video_den && !vs_rise &&
              pixel_x < cnt_w'(source_h) && pixel_y < cnt_w'(source_v);
    wr      = want && !wrfifo_full;
    ovf     = want && wrfifo_full;
    last    = pixel_x == cnt_w'(source_h - 1) && pixel_y == cnt_w'(source_v - 1);
    state_n = vs_rise ? SYNC : ovf ? DROP : (state == SYNC && !vs_act) ? ACTIVE : state;
  end
  always_ff @(posedge pixel_clock) begin
    if (!reset) state <= WAIT_SYNC;
    else        state <= state_n;
  end
  always_ff @(posedge pixel_clock) begin
    if (!reset) begin
      wr_load         <= 1'b0;
      wrfifo_wren     <= 1'b0;
      wrfifo_din      <= '0;
      frame_done      <= 1'b0;
      frame_overflow  <= 1'b0;
      overflow_sticky <= 1'b0;
    end else begin
      wr_load         <= vs_act;
      wrfifo_wren     <= wr;
      wrfifo_din      <= wr ? {video_pixel, pad_byte} : wrfifo_din;
      frame_done      <= wr && last;
      frame_overflow  <= ovf;
      overflow_sticky <= overflow_sticky || ovf;
    end
  end
endmodule

// File: tb/tb_video_capture_writer.sv
// tb_video_capture_writer: scoreboard bench driving both vsync polarities with one stimulus stream
module tb_video_capture_writer;
  localparam int SH = 8, SV = 6;
  logic clk = 0, reset = 0, vs = 0, vs_n, hs = 0, den = 0, full = 0;
  logic [23:0] pix = '0;
  logic wr_load[2], wr_clk[2], wren[2], done[2], ovf[2], sticky[2];
  logic [31:0] din[2];
  logic [32:0] q0[$], q1[$];
  int n_chk = 0, n_pass = 0, fr = 0;
  int got_wren[2], got_done[2], got_ovf[2];
  int fx = -1, fy = -1, ax = -1, ay = -1, rx = -1, ry = -1;
  bit mon_en = 0, armed = 0, dropping = 0;
  logic vs_smp = 0;
  assign vs_n = ~vs;
  always #5 clk = ~clk;
  video_capture_writer #(.source_h(SH), .source_v(SV), .video_vsync_pol(1'b1)) dut_p (
    .pixel_clock(clk), .reset(reset), .video_vsync(vs), .video_hsync(hs), .video_den(den),
    .video_pixel(pix), .wr_load(wr_load[0]), .wr_clk(wr_clk[0]), .wrfifo_wren(wren[0]),
    .wrfifo_din(din[0]), .wrfifo_full(full), .frame_done(done[0]), .frame_overflow(ovf[0]),
    .overflow_sticky(sticky[0]));
  video_capture_writer #(.source_h(SH), .source_v(SV), .video_vsync_pol(1'b0)) dut_n (
    .pixel_clock(clk), .reset(reset), .video_vsync(vs_n), .video_hsync(hs), .video_den(den),
    .video_pixel(pix), .wr_load(wr_load[1]), .wr_clk(wr_clk[1]), .wrfifo_wren(wren[1]),
    .wrfifo_din(din[1]), .wrfifo_full(full), .frame_done(done[1]), .frame_overflow(ovf[1]),
    .overflow_sticky(sticky[1]));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask
  task automatic mon(input int i);
    logic [32:0] e;
    chk($sformatf("wr_load[%0d]", i), wr_load[i], vs_smp);
    if (ovf[i]) got_ovf[i]++;
    if (done[i]) begin
      got_done[i]++;
      chk($sformatf("done_with_wren[%0d]", i), wren[i], 1);
    end
    if (wren[i]) begin
      got_wren[i]++;
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0))
        chk($sformatf("unexpected_wren[%0d]", i), wren[i], 0);
      else begin
        if (i == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("din_done[%0d]", i), {done[i], din[i]}, e);
      end
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    mon(0);
    mon(1);
  end
  task automatic cyc(input logic v, input logic d, input logic [23:0] p, input logic f, input logic r);
    vs = v; den = d; pix = p; full = f; reset = r; hs = !d;
    @(posedge clk); #1;
    vs_smp = v & r;
  endtask
  task automatic push(input logic [32:0] e);
    q0.push_back(e);
    q1.push_back(e);
  endtask
  task automatic out_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_outs[%0d]", tag, i), {wr_load[i], wren[i], din[i], done[i], ovf[i]}, 0);
      chk($sformatf("%s_sticky[%0d]", tag, i), sticky[i], 0);
    end
  endtask
  task automatic frame(input int w, input int h, input bit sync);
    bit stop;
    logic [23:0] p;
    logic lastp;
    stop = 0;
    if (sync) begin
      for (int i = 0; i < 3; i++) cyc(1, 0, '0, 0, 1);
      armed = 1;
      dropping = 0;
    end
    for (int i = 0; i < 2; i++) cyc(0, 0, '0, 0, 1);
    for (int y = 0; y < h && !stop; y++) begin
      for (int x = 0; x < w && !stop; x++) begin
        p = {8'(fr), 8'(y), 8'(x)};
        lastp = x == SH - 1 && y == SV - 1;
        if (x == ax && y == ay) begin
          cyc(1, 1, p, 0, 1);
          stop = 1;
        end else if (x == rx && y == ry) begin
          armed = 0;
          cyc(0, 1, p, 0, 0);
          out_zero("midline_reset");
        end else begin
          if (armed && !dropping && x < SH && y < SV) begin
            if (x == fx && y == fy) dropping = 1;
            else push({lastp, p, 8'h00});
          end
          cyc(0, 1, p, x == fx && y == fy, 1);
        end
      end
      if (!stop) for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 1);
    end
    if (!stop) for (int i = 0; i < 2; i++) cyc(0, 0, '0, 0, 1);
    fr++;
  endtask
  task automatic expect_counts(input string tag, input int wr, input int dn, input int of);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_wrens[%0d]", tag, i), got_wren[i], wr);
      chk($sformatf("%s_frame_done[%0d]", tag, i), got_done[i], dn);
      chk($sformatf("%s_overflow[%0d]", tag, i), got_ovf[i], of);
      got_wren[i] = 0;
      got_done[i] = 0;
      got_ovf[i] = 0;
    end
  endtask
  task automatic expect_sticky(input string tag, input logic v);
    for (int i = 0; i < 2; i++) chk($sformatf("%s_sticky[%0d]", tag, i), sticky[i], v);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      got_wren[i] = 0;
      got_done[i] = 0;
      got_ovf[i] = 0;
    end
    repeat (3) cyc(0, 0, '0, 0, 0);
    out_zero("reset");
    for (int i = 0; i < 2; i++) chk($sformatf("wr_clk[%0d]", i), wr_clk[i], 1);
    mon_en = 1;
    frame(12, 3, 0);
    expect_counts("midframe_start", 0, 0, 0);
    frame(12, 9, 1);
    expect_counts("full_frame", 48, 1, 0);
    fx = 3; fy = 2;
    frame(12, 9, 1);
    fx = -1; fy = -1;
    expect_counts("overflow_frame", 19, 0, 1);
    expect_sticky("overflow_frame", 1);
    frame(12, 9, 1);
    expect_counts("after_overflow", 48, 1, 0);
    expect_sticky("after_overflow", 1);
    frame(6, 4, 1);
    expect_counts("small_input", 24, 0, 0);
    ax = 3; ay = 3;
    frame(12, 9, 1);
    ax = -1; ay = -1;
    repeat (2) cyc(1, 0, '0, 0, 1);
    expect_counts("vsync_abort", 27, 0, 0);
    frame(12, 9, 1);
    expect_counts("after_abort", 48, 1, 0);
    rx = 4; ry = 2;
    frame(12, 9, 1);
    rx = -1; ry = -1;
    expect_counts("reset_frame", 20, 0, 0);
    expect_sticky("reset_frame", 0);
    frame(12, 9, 1);
    expect_counts("after_reset", 48, 1, 0);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/video_capture_writer.md
Name: video_capture_writer

Overview:
Ingress counterpart of the display driver: accepts a raster video stream (vsync/hsync/den/24-bit RGB) from the ISP/sensor path. It crops the stream to a source_h x source_v window and packs each pixel into the 32-bit write FIFO of the frame buffer. It raises the frame-buffer write reload signal on each vsync, and detects FIFO overflow, dropping the rest of a frame cleanly instead of corrupting line alignment.

Parameters:
source_h, 800, active pixels per line written to frame buffer
source_v, 480, active lines per frame written to frame buffer
video_vsync_pol, 1, 1 = vsync active-high at input, 0 = active-low
cnt_w, 14, width of pixel_x / pixel_y counters

Ports:
pixel_clock  input  1  sole clock; video input and write FIFO both run on it
reset  input  1  synchronous, active-low reset
video_vsync  input  1  input frame sync, polarity per video_vsync_pol
video_hsync  input  1  input line sync (informational only; line ends detected from den)
video_den  input  1  input data-enable, high during visible pixels
video_pixel  input  24  input pixel, {R,G,B} high to low
wr_load  output  1  frame-buffer write reload, high while normalised vsync is active
wr_clk  output  1  write FIFO clock, tied to pixel_clock
wrfifo_wren  output  1  write FIFO write enable
wrfifo_din  output  32  write data, {pixel[23:0], 8'h00}
wrfifo_full  input  1  write FIFO full, sampled in the same cycle as the write decision
frame_done  output  1  one-cycle pulse when the last in-window pixel of a frame is written
frame_overflow  output  1  one-cycle pulse when a frame is aborted because of full
overflow_sticky  output  1  set on any overflow, cleared only by reset

Behaviour:
- Normalised vsync: vs_act = video_vsync when pol=1, else ~video_vsync. vs_rise = vs_act & ~vs_act_d (vs_act_d is a registered copy).
- All outputs are registered except wr_clk. Reset (reset=0 at a pixel_clock edge): wr_load=0, wrfifo_wren=0, wrfifo_din=0, frame_done=0, frame_overflow=0, overflow_sticky=0, pixel_x=pixel_y=0, state=WAIT_SYNC. Reset asserted mid-frame discards that frame; capture resumes only after the next vs_rise.
- wr_load = vs_act registered, so it has 1 cycle latency.
- States:
  WAIT_SYNC: ignore den. On vs_rise go to SYNC.
  SYNC: hold x=y=0. Go to ACTIVE when vs_act falls.
  ACTIVE: capture pixels. On vs_rise go to SYNC.
  DROP: ignore den. On vs_rise go to SYNC.
- Counters (ACTIVE only):
  - pixel_x increments on each den=1 cycle.
  - On the den falling edge (den_d=1, den=0), pixel_x returns to 0 and pixel_y increments.
  - Both counters saturate at 2^cnt_w-1 and never wrap.
- Write decision in cycle t, registered at t+1: want = ACTIVE & den & (pixel_x<source_h) & (pixel_y<source_v).
  - want & ~wrfifo_full: wrfifo_wren=1 and wrfifo_din={video_pixel,8'h00} at t+1.
  - want & wrfifo_full: no write. frame_overflow pulses at t+1, overflow_sticky is set, and the state goes to DROP.
- Pixels outside the window (x>=source_h or y>=source_v) are silently discarded. An input smaller than the window produces a short frame with no padding, and frame_done is not pulsed.
- frame_done pulses at t+1 when the write for (x=source_h-1, y=source_v-1) is accepted.
- If vs_rise coincides with den=1, vsync wins: no write, and the counters clear.
- A vsync arriving mid-line aborts the frame: the counters clear and no frame_done is pulsed.
- Throughput: 1 pixel per clock, with no back-pressure to the input.

Decomposition:
- Shared package video_pkg holds:
  - Constants: state encoding (WAIT_SYNC, SYNC, ACTIVE, DROP), padding byte 8'h00, default cnt_w.
  - Function for vsync polarity normalisation, shared with the timing generator.
- One natural sub-module, video_pos_counter: den edge detection plus saturating x/y counters with sync clear. It is reusable by other ISP stages.

Test Plan:
- 1280x720 input, source 800x480, FIFO never full -> exactly 384000 wrens per frame, first wrfifo_din={pixel(0,0),8'h00}, one frame_done one cycle after the write of (799,479).
- wrfifo_full asserted at pixel (100,10) -> no write that cycle, frame_overflow pulse, overflow_sticky=1, zero wrens until next vs_rise; the next frame then writes a full 384000 with overflow_sticky still 1.
- Input 640x400 with source 800x480 -> 256000 wrens, no frame_done, no overflow.
- Stream started mid-frame after reset -> zero wrens until the first vs_rise; wr_load follows vs_act with 1 cycle latency; repeat with video_vsync_pol=0.
- vsync edge injected at line 200 of a frame -> counters clear, no frame_done; the next frame captures normally starting at (0,0).
- reset=0 for 1 cycle mid-line -> all outputs 0 on the next edge, state WAIT_SYNC, overflow_sticky cleared.
